// File: rtl/mod_sseg_hex_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_pkg
//  Brief    : Shared constants for the hex-to-seven-segment formatter:
//             FSM encoding, register selects and segment lookup table.
//  Revision : 1.0
// ============================================================================
package sseg_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_PUSH = 2'd2;

    localparam logic REG_VALUE  = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    localparam logic [7:0] BLANK_PAT = 8'hFF;

    // Active-low g..a patterns, index 15 first so SEG_LUT[n] is digit n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [7:0] seg_byte(input logic [6:0] seg,
                                            input logic       blank,
                                            input logic       dp_on);
        return blank ? BLANK_PAT : {~dp_on, seg};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_sseg_hex_if.sv
`default_nettype none
// ============================================================================
//  Module   : mod_sseg_hex_if
//  Brief    : Bus-side and display-side signal bundle of the hex formatter.
//  Revision : 1.0
// ============================================================================
interface mod_sseg_hex_if;

    logic        ie;
    logic        de;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic        drw;
    logic [31:0] din;
    logic        sseg_we;
    logic [31:0] sseg_data;

    modport master (
        output ie, de, iaddr, daddr, drw, din,
        input  sseg_we, sseg_data
    );

    modport slave (
        input  ie, de, iaddr, daddr, drw, din,
        output sseg_we, sseg_data
    );

endinterface
`default_nettype wire

// File: rtl/mod_sseg_hex_rom.sv
`default_nettype none
// ============================================================================
//  Module   : mod_sseg_hex_rom
//  Brief    : Combinational nibble to active-low 7-segment pattern lookup.
//  Revision : 1.0
// ============================================================================
module mod_sseg_hex_rom
    import sseg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_LUT[i_nibble];

endmodule
`default_nettype wire

// File: rtl/mod_sseg_hex.sv
`default_nettype none
// ============================================================================
//  Module   : mod_sseg_hex
//  Brief    : Memory-mapped hex formatter feeding the seven-segment register.
//             Optional decimal-point support via macro SSEG_HEX_DP_EN.
//  Revision : 1.0
// ============================================================================
module mod_sseg_hex
    import sseg_pkg::*;
#(
    parameter int BASE_OFFSET_BITS = 3
) (
    input  wire               clk,
    input  wire               rst,
    mod_sseg_hex_if.slave     bus,
    output wire        [31:0] iout,
    output wire        [31:0] dout
);

    logic [1:0]  r_state;
    logic [1:0]  r_idx;
    logic [15:0] r_value;
    logic [3:0]  r_blank;
    logic        r_busy;
    logic        r_overrun;
    logic        r_sseg_we;
    logic [31:0] r_sseg_data;

    logic        w_sel;
    logic        w_wr_value;
    logic        w_wr_status;
    logic        w_accept;
    logic        w_drop;
    logic [3:0]  w_nibble;
    logic [6:0]  w_seg;
    logic        w_dp_bit;
    logic [3:0]  w_dp_rd;
    logic [7:0]  w_byte;
    logic [31:0] w_rd_value;
    logic [31:0] w_rd_status;
    logic        w_unused;

    assign w_sel       = bus.daddr[BASE_OFFSET_BITS-1];
    assign w_wr_value  = bus.de & bus.drw & (w_sel == REG_VALUE);
    assign w_wr_status = bus.de & bus.drw & (w_sel == REG_STATUS);
    // PUSH is the last busy cycle; a write landing there starts the next job.
    assign w_accept    = w_wr_value & ((r_state == ST_IDLE) | (r_state == ST_PUSH));
    assign w_drop      = w_wr_value & (r_state == ST_CONV);

    assign w_nibble = r_value[{r_idx, 2'b00} +: 4];

    mod_sseg_hex_rom u_rom (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

`ifdef SSEG_HEX_DP_EN
    logic [3:0] r_dp;
    assign w_dp_bit = r_dp[r_idx];
    assign w_dp_rd  = r_dp;
    assign w_unused = ^{bus.iaddr, bus.din[31:24],
                        bus.daddr[31:BASE_OFFSET_BITS], bus.daddr[BASE_OFFSET_BITS-2:0]};
`else
    assign w_dp_bit = 1'b0;
    assign w_dp_rd  = 4'h0;
    assign w_unused = ^{bus.iaddr, bus.din[31:20],
                        bus.daddr[31:BASE_OFFSET_BITS], bus.daddr[BASE_OFFSET_BITS-2:0]};
`endif

    assign w_byte = seg_byte(w_seg, r_blank[r_idx], w_dp_bit);

    always_ff @(negedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= 2'd0;
            r_value     <= 16'h0000;
            r_blank     <= 4'h0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_sseg_we   <= 1'b0;
            r_sseg_data <= 32'hFFFF_FFFF;
        end else begin
            r_sseg_we <= 1'b0;

            if (w_wr_status) begin
                r_overrun <= 1'b0;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                ST_IDLE, ST_PUSH: begin
                    if (w_accept) begin
                        r_value <= bus.din[15:0];
                        r_blank <= bus.din[19:16];
                        r_idx   <= 2'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_CONV;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    r_sseg_data[{r_idx, 3'b000} +: 8] <= w_byte;
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_state   <= ST_PUSH;
                        r_sseg_we <= 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SSEG_HEX_DP_EN
    always_ff @(negedge clk) begin
        if (rst) begin
            r_dp <= 4'h0;
        end else if (w_accept) begin
            r_dp <= bus.din[23:20];
        end
    end
`endif

    assign w_rd_value  = {8'h00, w_dp_rd, r_blank, r_value};
    assign w_rd_status = {30'h0, r_overrun, r_busy};

    assign dout = bus.de ? ((w_sel == REG_STATUS) ? w_rd_status : w_rd_value)
                         : 32'hzzzz_zzzz;
    assign iout = bus.ie ? 32'h0000_0000 : 32'hzzzz_zzzz;

    assign bus.sseg_we   = r_sseg_we;
    assign bus.sseg_data = r_sseg_data;

endmodule
`default_nettype wire
